dsp_mac_pipe: RTL and testbench

//  Parametrised, pipelined multiply-accumulate (z <= z + a*b) for the DSP38 tile family.

---
 rtl/dsp_mac_pipe.sv | 150 +++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Three-stage pipelined multiply-accumulate with signed/unsigned mode, accumulator load,
// optional saturation and a sticky overflow flag.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 38,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 signed_mode,
  input  logic                 acc_clear,
  output logic [ACC_WIDTH-1:0] z_out,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  generate
    if (ACC_WIDTH < P_W) begin : g_width_check
      $error("dsp_mac_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
  endgenerate

  logic signed [A_WIDTH-1:0]   a_p0;
  logic signed [B_WIDTH-1:0]   b_p0;
  logic                        sgn_p0, clr_p0, vld_p0;
  logic signed [P_W-1:0]       prod_p1;
  logic                        sgn_p1, clr_p1, vld_p1;
  logic signed [ACC_WIDTH-1:0] z_p2;
  logic                        ovf_p2, vld_p2;

  logic signed [P_W-1:0]       a_ext, b_ext, prod;
  logic signed [ACC_WIDTH-1:0] ext_p, z_nxt;
  logic signed [ACC_WIDTH:0]   sum_full;
  logic                        ovf_hit, ovf_nxt;

  function automatic logic signed [ACC_WIDTH-1:0] extend_prod(
    input logic signed [P_W-1:0] p,
    input logic                  sgn
  );
    logic signed [ACC_WIDTH-1:0] r;
    r          = {ACC_WIDTH{sgn & p[P_W-1]}};
    r[P_W-1:0] = p;
    return r;
  endfunction

  function automatic logic acc_overflow(
    input logic signed [ACC_WIDTH:0] sum,
    input logic                      sgn
  );
    return sgn ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
  endfunction

  // Clamp toward the sign of the true (ACC_WIDTH+1)-bit sum.
  function automatic logic signed [ACC_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH:0] sum,
    input logic                      sgn
  );
    logic signed [ACC_WIDTH-1:0] r;
    r = '1;
    if (sgn) begin
      r               = sum[ACC_WIDTH] ? '0 : '1;
      r[ACC_WIDTH-1]  = sum[ACC_WIDTH];
    end
    return r;
  endfunction

  // ---- stage 1: operand capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      sgn_p0 <= 1'b0;
      clr_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        a_p0   <= a;
        b_p0   <= b;
        sgn_p0 <= signed_mode;
        clr_p0 <= acc_clear;
      end
    end
  end

  // Extending both operands to P_W makes one multiplier serve both modes.
  always_comb begin
    a_ext = {{B_WIDTH{sgn_p0 & a_p0[A_WIDTH-1]}}, a_p0};
    b_ext = {{A_WIDTH{sgn_p0 & b_p0[B_WIDTH-1]}}, b_p0};
    prod  = a_ext * b_ext;
  end

  // ---- stage 2: product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
      sgn_p1  <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        prod_p1 <= prod;
        sgn_p1  <= sgn_p0;
        clr_p1  <= clr_p0;
      end
    end
  end

  always_comb begin
    ext_p    = extend_prod(prod_p1, sgn_p1);
    sum_full = $signed({sgn_p1 & z_p2[ACC_WIDTH-1], z_p2})
             + $signed({sgn_p1 & ext_p[ACC_WIDTH-1], ext_p});
    ovf_hit  = acc_overflow(sum_full, sgn_p1);
    z_nxt    = sum_full[ACC_WIDTH-1:0];
    ovf_nxt  = ovf_p2 | ovf_hit;
    if (clr_p1) begin
      z_nxt   = ext_p;
      ovf_nxt = 1'b0;
    end else if (ovf_hit && SATURATE != 0) begin
      z_nxt = saturate(sum_full, sgn_p1);
    end
  end

  // ---- stage 3: accumulate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      z_p2   <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        z_p2   <= z_nxt;
        ovf_p2 <= ovf_nxt;
      end
    end
  end

  assign z_out     = z_p2;
  assign out_valid = vld_p2;
  assign overflow  = ovf_p2;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: wrapping and saturating instances driven in parallel,
// scored against a wide-integer accumulator model.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;
  localparam int AW = 20;
  localparam int BW = 18;
  localparam int ZW = 38;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          signed_mode = 1'b0;
  logic          acc_clear = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic [ZW-1:0] zw, zs;
  logic          vw, vs, ow, os;

  typedef struct packed {
    logic [ZW-1:0] zw;
    logic [ZW-1:0] zs;
    logic          ow;
    logic          os;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [ZW-1:0] mzw = '0, mzs = '0;
  logic          mow = 1'b0, mos = 1'b0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ZW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .signed_mode(signed_mode), .acc_clear(acc_clear),
    .z_out(zw), .out_valid(vw), .overflow(ow));

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ZW), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .signed_mode(signed_mode), .acc_clear(acc_clear),
    .z_out(zs), .out_valid(vs), .overflow(os));

  function automatic void model(input logic [ZW-1:0] z, input logic ov,
                                input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                                input logic s, input logic c, input bit sat,
                                output logic [ZW-1:0] nz, output logic no);
    longint av, bv, prod, zv, sum, lo, hi;
    av   = s ? longint'($signed(ai)) : longint'(ai);
    bv   = s ? longint'($signed(bi)) : longint'(bi);
    prod = av * bv;
    hi   = s ? (longint'(1) <<< (ZW - 1)) - 1 : (longint'(1) <<< ZW) - 1;
    lo   = s ? -(longint'(1) <<< (ZW - 1)) : 0;
    if (c) begin
      nz = ZW'(prod);
      no = 1'b0;
    end else begin
      zv  = s ? longint'($signed(z)) : longint'(z);
      sum = zv + prod;
      if (sum > hi || sum < lo) begin
        no = 1'b1;
        nz = !sat ? ZW'(sum) : (sum > hi ? ZW'(hi) : ZW'(lo));
      end else begin
        nz = ZW'(sum);
        no = ov;
      end
    end
  endfunction

  // Drives one cycle from a negedge; a valid sample pushes its expected result.
  task automatic step(input logic v, input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                      input logic s, input logic c);
    exp_t e;
    in_valid = v; a = ai; b = bi; signed_mode = s; acc_clear = c;
    if (v) begin
      model(mzw, mow, ai, bi, s, c, 1'b0, mzw, mow);
      model(mzs, mos, ai, bi, s, c, 1'b1, mzs, mos);
      e.zw = mzw; e.zs = mzs; e.ow = mow; e.os = mos;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    sbq.delete();
    mzw = '0; mzs = '0; mow = 1'b0; mos = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = AW'($urandom); b = BW'($urandom);
      signed_mode = 1'($urandom); acc_clear = 1'($urandom);
      @(negedge clk);
      total++;
      if ({zw, zs, vw, vs, ow, os} !== '0) begin
        bad++;
        $display("FAIL reset_hold: z=%h/%h v=%b/%b ovf=%b/%b, required all zero", zw, zs, vw, vs, ow, os);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (vw !== 1'b0 || vs !== 1'b0 || zw !== '0) begin
        bad++;
        $display("FAIL reset_release: v=%b/%b z=%h, required v=0 z=0", vw, vs, zw);
      end
    end
  endtask

  task automatic test_unsigned();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      if (k < 2) step(1'b1, 20'h7FFFF, 18'h1FFFF, 1'b0, 1'(k == 0));
      else       step(1'b0, '0, '0, 1'b0, 1'b0);
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL unsigned_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL unsigned_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
      total++;
      if ((k == 2 && (zw !== 38'h0FFFF60001 || vw !== 1'b1)) ||
          (k == 3 && (zw !== 38'h1FFFEC0002 || vw !== 1'b1)) ||
          (k == 4 && (zw !== 38'h1FFFEC0002 || vw !== 1'b0)) ||
          (k < 2 && vw !== 1'b0)) begin
        bad++; $display("FAIL unsigned_value step%0d: z=%h v=%b", k, zw, vw);
      end
    end
  endtask

  task automatic test_signed();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      step(1'b1, 20'hFFFFF, 18'h00002, 1'b1, 1'b1);
      else if (k == 1) step(1'b1, 20'h00001, 18'h00002, 1'b1, 1'b0);
      else             step(1'b0, '0, '0, 1'b1, 1'b0);
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL signed_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL signed_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
    end
    total++;
    if (zw !== '0 || zs !== '0 || ow !== 1'b0 || os !== 1'b0) begin
      bad++; $display("FAIL signed_final: z=%h/%h ovf=%b/%b, required 0 and no overflow", zw, zs, ow, os);
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic [5:0] vpat = 6'b001001;
    logic [5:0] pulse = 6'b100100;
    for (int k = 0; k < 6; k++) begin
      step(vpat[k], 20'd3, 18'd5, 1'b0, 1'(k == 0));
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL bubble_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL bubble_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
      total++;
      if (vw !== pulse[k]) begin
        bad++; $display("FAIL bubble_latency step%0d: out_valid=%b required %b", k, vw, pulse[k]);
      end
      if (k >= 2) begin
        total++;
        if (zw !== ((k == 5) ? ZW'(30) : ZW'(15))) begin
          bad++; $display("FAIL bubble_hold step%0d: z=%0d required %0d", k, zw, (k == 5) ? 30 : 15);
        end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) step(1'b1, 20'h7FFFF, 18'h1FFFF, 1'b1, 1'(k == 0));
      else       step(1'b0, '0, '0, 1'b1, 1'b0);
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL sat_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL sat_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
    end
    total++;
    if (zs !== 38'h1FFFFFFFFF || os !== 1'b1) begin
      bad++; $display("FAIL sat_clamp: z=%h ovf=%b required 1fffffffff/1", zs, os);
    end
    total++;
    if (zw !== 38'h2FFFE20003 || ow !== 1'b1) begin
      bad++; $display("FAIL sat_wrap: z=%h ovf=%b required 2fffe20003/1", zw, ow);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 20'h7FFFF, 18'h1FFFF, 1'b1, 1'b0);
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL async_pre_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL async_pre_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({zw, zs, vw, vs, ow, os} !== '0) begin
      bad++; $display("FAIL async_assert: z=%h/%h v=%b/%b ovf=%b/%b, required all zero before the edge", zw, zs, vw, vs, ow, os);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 4)      step(1'b1, 20'd3, 18'd5, 1'b0, 1'b1);
      else if (k == 5) step(1'b1, 20'd2, 18'd2, 1'b0, 1'b0);
      else             step(1'b0, '0, '0, 1'b0, 1'b0);
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL async_post_pulse step%0d: out_valid=%b/%b with no sample due", k, vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL async_post_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
    end
    total++;
    if (zw !== ZW'(19) || ow !== 1'b0 || sbq.size() != 0) begin
      bad++; $display("FAIL async_resume: z=%0d ovf=%b pending=%0d, required 19/0/0", zw, ow, sbq.size());
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   sent = 0;
    int   cyc = 0;
    while ((sent < 600 || sbq.size() != 0) && cyc < 2000) begin
      if (sent < 600 && $urandom_range(0, 4) != 0) begin
        step(1'b1, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        sent++;
      end else begin
        step(1'b0, AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
      end
      cyc++;
      if (vw || vs) begin
        total++;
        if (vw !== vs || sbq.size() == 0) begin
          bad++; $display("FAIL random_pulse: out_valid=%b/%b with no sample due", vw, vs);
        end else begin
          e = sbq.pop_front();
          if ({zw, zs, ow, os} !== e) begin
            bad++; $display("FAIL random_score: got %h/%h/%b/%b required %h/%h/%b/%b", zw, zs, ow, os, e.zw, e.zs, e.ow, e.os);
          end
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL random_drain: %0d samples never produced out_valid, required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_bubbles();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
